class_argmax_scanner: RTL and testbench
=======================================

// Module: class_argmax_scanner
// PURPOSE
// - Consumer of the packed per-class score bus produced by the vector-matrix stage (N scores, VALUE_SIZE bits each).
// - Captures one score vector on a valid/ready handshake and scans it sequentially, one score per cycle.
// - Reports the winning class index and its score on a second valid/ready handshake; final stage of the classifier.
// PARAMETERS
// - N          10  number of classes/scores per vector; N>=2 required
// - VALUE_SIZE 26  width of one score, two's-complement signed
// - IDX_W      $clog2(N) (localparam) width of class index
// PORTS
// - clk         in   1             single clock, rising edge
// - GlobalReset in   1             synchronous, active-high reset
// - value_in    in   VALUE_SIZE*N  packed scores; score j = value_in[(j+1)*VALUE_SIZE-1 : j*VALUE_SIZE]
// - in_valid    in   1             value_in is valid
// - in_ready    out  1             scanner can accept a vector
// - class_out   out  IDX_W         index of maximum score
// - max_value   out  VALUE_SIZE    maximum score (signed)
// - out_valid   out  1             class_out/max_value valid
// - out_ready   in   1             downstream accepts result
// BEHAVIOUR
// - Reset (any cycle): state=IDLE, out_valid=0, class_out=0, max_value=0, scan counter=0, captured vector discarded.
// - in_ready = (state==IDLE) && !GlobalReset; combinational from state only, never depends on in_valid.
// - FSM IDLE -> SCAN -> DONE -> IDLE.
// - IDLE: on edge with in_valid&&in_ready (accept edge E0):
//   - register full value_in;
//   - best_idx=0, best_val=score0, cnt=1;
//   - go to SCAN.
// - IDLE: in_valid without in_ready has no effect.
// - SCAN: each edge Ek (k=1..N-1) compares score[cnt] against best_val.
//   - Signed strict greater-than; on win, best_idx=cnt, best_val=score[cnt].
//   - cnt increments.
//   - At E(N-1) the final compare result is written to class_out/max_value, state=DONE, out_valid=1.
// - Latency: out_valid first observable after the (N-1)th rising edge following E0.
// - Throughput: one vector per N+1 cycles with out_ready held high.
// - DONE: out_valid=1; class_out/max_value held stable while out_ready=0; in_ready=0.
//   - On out_valid&&out_ready edge: out_valid=0, state=IDLE.
//   - class_out/max_value keep their last values until overwritten by the next result.
// - value_in sampled only at accept edge; later changes on value_in do not affect the running scan.
// - Ties: earliest (lowest) index wins.
// - Full signed range supported: -2^(VALUE_SIZE-1) .. 2^(VALUE_SIZE-1)-1; no overflow possible (compare only).
// - No overlap: a new vector is never accepted in SCAN or DONE.
// - Reset mid-SCAN or mid-DONE: result discarded, no out_valid pulse, IDLE next cycle.
// STRUCTURE
// - Shared package: VALUE_SIZE (26), default N (10), clog2 function for IDX_W, FSM state encoding (IDLE/SCAN/DONE).
// - Sub-module score_compare: combinational signed a>b select.
//   - Inputs: candidate value/index, current best value/index.
//   - Outputs: next best value/index.
//   - Instantiated once.
// - Top: capture register, N:1 score mux on cnt, counter, FSM, output registers.
// TESTING (N=10, VALUE_SIZE=26)
// - Reset 2 cycles -> out_valid=0, class_out=0, max_value=0; in_ready=1 first cycle after release.
// - score j = 100*j -> class_out=9, max_value=900; out_valid rises 9 edges after accept.
// - all scores -5, score3 = -1 (26'h3FFFFFF) -> class_out=3, max_value=-1 (signed compare check).
// - score2=score7=1000, rest 0 -> class_out=2 (tie to lowest index).
// - score0=-2^25, score5=2^25-1, rest 0; out_ready low 5 cycles -> class_out=5 held stable, in_ready=0, extra in_valid ignored; out_ready high -> IDLE, next vector accepted.
// - GlobalReset asserted at scan edge E4 -> no out_valid; next vector (score6=42, rest 0) -> class_out=6, max_value=42.

Source files
------------

// File: rtl/class_argmax_scanner_pkg.sv
// Shared definitions for the class argmax scanner: default sizes, index-width
// helper and FSM state encoding.
package class_argmax_scanner_pkg;

    localparam int unsigned DEFAULT_VALUE_SIZE = 26;
    localparam int unsigned DEFAULT_N          = 10;

    // Ceiling log2, with a minimum of 1 bit so the index is never zero-width
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/class_argmax_scanner_score_compare.sv
// Signed candidate-versus-best select; ties keep the current best, so the
// earlier index wins.
module score_compare
    import class_argmax_scanner_pkg::*;
#(
    parameter int unsigned VALUE_SIZE = DEFAULT_VALUE_SIZE,
    parameter int unsigned IDX_W      = clog2(DEFAULT_N)
) (
    input  logic [VALUE_SIZE-1:0] cand_val,
    input  logic [IDX_W-1:0]      cand_idx,
    input  logic [VALUE_SIZE-1:0] best_val,
    input  logic [IDX_W-1:0]      best_idx,
    output logic [VALUE_SIZE-1:0] next_val_c,
    output logic [IDX_W-1:0]      next_idx_c
);

    logic cand_wins;

    assign cand_wins = $signed(cand_val) > $signed(best_val);

    always_comb begin
        next_val_c = best_val;
        next_idx_c = best_idx;
        if (cand_wins) begin
            next_val_c = cand_val;
            next_idx_c = cand_idx;
        end
    end

endmodule

// File: rtl/class_argmax_scanner.sv
// Captures one packed score vector, scans it one score per cycle and returns
// the index and value of the largest signed score on a valid/ready handshake.
module class_argmax_scanner
    import class_argmax_scanner_pkg::*;
#(
    parameter  int unsigned N          = DEFAULT_N,
    parameter  int unsigned VALUE_SIZE = DEFAULT_VALUE_SIZE,
    localparam int unsigned IDX_W      = clog2(N)
) (
    input  logic                    clk,
    input  logic                    GlobalReset,
    input  logic [VALUE_SIZE*N-1:0] value_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [IDX_W-1:0]        class_out,
    output logic [VALUE_SIZE-1:0]   max_value,
    output logic                    out_valid,
    input  logic                    out_ready
);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic [VALUE_SIZE*N-1:0] vec_q, vec_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic [VALUE_SIZE-1:0]   best_val_q, best_val_d;
    logic [IDX_W-1:0]        class_q, class_d;
    logic [VALUE_SIZE-1:0]   max_q, max_d;
    logic                    out_valid_q, out_valid_d;

    logic [VALUE_SIZE-1:0]   score_sel;
    logic [VALUE_SIZE-1:0]   cmp_val;
    logic [IDX_W-1:0]        cmp_idx;
    logic                    last_score;

    // Ready depends on state only, so upstream may wait on it without a loop
    assign in_ready  = (state_q == ST_IDLE) && !GlobalReset;
    assign class_out = class_q;
    assign max_value = max_q;
    assign out_valid = out_valid_q;

    // N:1 score mux on the scan counter
    always_comb begin
        score_sel = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (cnt_q == IDX_W'(j)) begin
                score_sel = vec_q[j*VALUE_SIZE +: VALUE_SIZE];
            end
        end
    end

    score_compare #(
        .VALUE_SIZE (VALUE_SIZE),
        .IDX_W      (IDX_W)
    ) u_score_compare (
        .cand_val   (score_sel),
        .cand_idx   (cnt_q),
        .best_val   (best_val_q),
        .best_idx   (best_idx_q),
        .next_val_c (cmp_val),
        .next_idx_c (cmp_idx)
    );

    assign last_score = (cnt_q == IDX_W'(N - 1));

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        best_idx_d  = best_idx_q;
        best_val_d  = best_val_q;
        class_d     = class_q;
        max_d       = max_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    vec_d      = value_in;
                    best_idx_d = '0;
                    best_val_d = value_in[VALUE_SIZE-1:0];
                    cnt_d      = IDX_W'(1);
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                best_idx_d = cmp_idx;
                best_val_d = cmp_val;
                cnt_d      = cnt_q + IDX_W'(1);
                if (last_score) begin
                    class_d     = cmp_idx;
                    max_d       = cmp_val;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                cnt_d       = '0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            vec_q       <= '0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            class_q     <= '0;
            max_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            best_idx_q  <= best_idx_d;
            best_val_q  <= best_val_d;
            class_q     <= class_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_class_argmax_scanner.sv
// Self-checking bench for class_argmax_scanner against an argmax reference model.
module tb_class_argmax_scanner;

    localparam int unsigned N  = 10;
    localparam int unsigned VS = 26;
    localparam int unsigned IW = 4;

    logic            clk;
    logic            GlobalReset;
    logic [VS*N-1:0] value_in;
    logic            in_valid;
    logic            in_ready;
    logic [IW-1:0]   class_out;
    logic [VS-1:0]   max_value;
    logic            out_valid;
    logic            out_ready;

    int errors;
    int checks;

    class_argmax_scanner #(.N(N), .VALUE_SIZE(VS)) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .value_in    (value_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .class_out   (class_out),
        .max_value   (max_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: first index holding the largest signed score
    function automatic int ref_argmax(input int s[N]);
        int best;
        best = 0;
        for (int j = 1; j < N; j++) begin
            if (s[j] > s[best]) best = j;
        end
        return best;
    endfunction

    function automatic logic [VS*N-1:0] pack(input int s[N]);
        logic [VS*N-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[j*VS +: VS] = VS'(s[j]);
        return v;
    endfunction

    function automatic int rand_score();
        return int'($urandom_range(0, 32'h3FFFFFF)) - 32'sh2000000;
    endfunction

    // Present one vector, then scramble value_in and wait for the result
    task automatic run_vec(input logic [VS*N-1:0] vec, output int lat,
                           output logic [IW-1:0] cls, output logic [VS-1:0] mx);
        @(negedge clk);
        value_in = vec;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < N; j++) value_in[j*VS +: VS] = VS'($urandom);
        lat = -1;
        cls = '0;
        mx  = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                cls = class_out;
                mx  = max_value;
                break;
            end
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        GlobalReset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready_during got=%b exp=0", in_ready);
        end
        GlobalReset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (class_out !== '0) begin
            errors++; $display("FAIL reset_class_out got=%0d exp=0", class_out);
        end
        checks++;
        if (max_value !== '0) begin
            errors++; $display("FAIL reset_max_value got=%h exp=0", max_value);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_ascending();
        int s[N];
        int lat;
        logic [IW-1:0] cls;
        logic [VS-1:0] mx;
        for (int j = 0; j < N; j++) s[j] = 100 * j;
        run_vec(pack(s), lat, cls, mx);
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL asc_latency got=%0d exp=9", lat);
        end
        checks++;
        if (cls !== 4'd9) begin
            errors++; $display("FAIL asc_class got=%0d exp=9", cls);
        end
        checks++;
        if (mx !== 26'd900) begin
            errors++; $display("FAIL asc_max got=%0d exp=900", mx);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL asc_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
        end
        checks++;
        if (class_out !== 4'd9 || max_value !== 26'd900) begin
            errors++; $display("FAIL asc_retain got=%0d/%0d exp=9/900", class_out, max_value);
        end
    endtask

    task automatic test_signed();
        int s[N];
        int lat;
        logic [IW-1:0] cls;
        logic [VS-1:0] mx;
        for (int j = 0; j < N; j++) s[j] = -5;
        s[3] = -1;
        run_vec(pack(s), lat, cls, mx);
        checks++;
        if (cls !== 4'd3 || mx !== 26'h3FFFFFF) begin
            errors++; $display("FAIL signed_cmp got=%0d/%h exp=3/3ffffff", cls, mx);
        end
        handshake();
    endtask

    task automatic test_tie();
        int s[N];
        int lat;
        logic [IW-1:0] cls;
        logic [VS-1:0] mx;
        for (int j = 0; j < N; j++) s[j] = 0;
        s[2] = 1000;
        s[7] = 1000;
        run_vec(pack(s), lat, cls, mx);
        checks++;
        if (cls !== 4'd2 || mx !== 26'd1000) begin
            errors++; $display("FAIL tie_lowest got=%0d/%0d exp=2/1000", cls, mx);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int s[N];
        int t[N];
        int lat;
        int e;
        logic [IW-1:0] cls;
        logic [VS-1:0] mx;
        for (int j = 0; j < N; j++) s[j] = 0;
        s[0] = -32'sh2000000;
        s[5] = 32'sh1FFFFFF;
        run_vec(pack(s), lat, cls, mx);
        checks++;
        if (cls !== 4'd5 || mx !== 26'h1FFFFFF) begin
            errors++; $display("FAIL bp_result got=%0d/%h exp=5/1ffffff", cls, mx);
        end
        for (int j = 0; j < N; j++) t[j] = 0;
        t[1] = 77;
        value_in = pack(t);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || class_out !== 4'd5 ||
                max_value !== 26'h1FFFFFF) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got v=%b r=%b %0d/%h exp v=1 r=0 5/1ffffff",
                         c, out_valid, in_ready, class_out, max_value);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
        for (int j = 0; j < N; j++) t[j] = rand_score();
        e = ref_argmax(t);
        run_vec(pack(t), lat, cls, mx);
        checks++;
        if (lat !== 9 || cls !== IW'(e) || mx !== VS'(t[e])) begin
            errors++; $display("FAIL bp_next got lat=%0d %0d/%h exp lat=9 %0d/%h",
                               lat, cls, mx, e, VS'(t[e]));
        end
        handshake();
    endtask

    task automatic test_reset_mid_scan();
        int s[N];
        int seen;
        int lat;
        logic [IW-1:0] cls;
        logic [VS-1:0] mx;
        for (int j = 0; j < N; j++) s[j] = 500 + j;
        @(negedge clk);
        value_in = pack(s);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        GlobalReset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        GlobalReset = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (out_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rst_mid_no_valid got=%0d exp=0", seen);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_idle got=%b exp=1", in_ready);
        end
        for (int j = 0; j < N; j++) s[j] = 0;
        s[6] = 42;
        run_vec(pack(s), lat, cls, mx);
        checks++;
        if (cls !== 4'd6 || mx !== 26'd42) begin
            errors++; $display("FAIL rst_mid_next got=%0d/%0d exp=6/42", cls, mx);
        end
        handshake();
    endtask

    task automatic test_random();
        int s[N];
        int e;
        int lat;
        logic [IW-1:0] cls;
        logic [VS-1:0] mx;
        for (int v = 0; v < 20; v++) begin
            for (int j = 0; j < N; j++) begin
                s[j] = (v % 2 == 0) ? rand_score() : int'($urandom_range(0, 3)) - 2;
            end
            e = ref_argmax(s);
            run_vec(pack(s), lat, cls, mx);
            checks++;
            if (lat !== 9 || cls !== IW'(e) || mx !== VS'(s[e])) begin
                errors++; $display("FAIL random v=%0d got lat=%0d %0d/%h exp lat=9 %0d/%h",
                                   v, lat, cls, mx, e, VS'(s[e]));
            end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        int s[N];
        int exp_idx[$];
        logic [VS-1:0] exp_val[$];
        int sent;
        int got;
        int last_cyc;
        int e;
        out_ready = 1'b1;
        sent = 0;
        got = 0;
        last_cyc = -1;
        for (int c = 0; c < 80 && got < 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (exp_idx.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected cycle=%0d got=%0d exp=none", c, class_out);
                end else begin
                    if (class_out !== IW'(exp_idx[0]) || max_value !== exp_val[0]) begin
                        errors++; $display("FAIL b2b_result n=%0d got=%0d/%h exp=%0d/%h",
                                           got, class_out, max_value, exp_idx[0], exp_val[0]);
                    end
                    void'(exp_idx.pop_front());
                    void'(exp_val.pop_front());
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (c - last_cyc !== int'(N) + 1) begin
                        errors++; $display("FAIL b2b_period got=%0d exp=%0d", c - last_cyc, N + 1);
                    end
                end
                last_cyc = c;
                got++;
            end
            if (in_ready && sent < 4) begin
                for (int j = 0; j < N; j++) s[j] = rand_score();
                e = ref_argmax(s);
                exp_idx.push_back(e);
                exp_val.push_back(VS'(s[e]));
                value_in = pack(s);
                in_valid = 1'b1;
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (got !== 4) begin
            errors++; $display("FAIL b2b_count got=%0d exp=4", got);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        GlobalReset = 1'b1;
        value_in    = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        test_reset();
        test_ascending();
        test_signed();
        test_tie();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
